// File: rtl/mdu_divider.sv
// Multi-cycle RV64M divide/remainder unit: restoring division, one quotient bit per cycle,
// with valid/ready handshakes on request and response.
module mdu_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned HW = 32;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            state_q, state_nx;
    logic [2:0]        op_q, op_nx;
    logic [XLEN-1:0]   a_q, a_nx;      // dividend, then quotient shift register
    logic [XLEN-1:0]   b_q, b_nx;      // divisor, then its magnitude
    logic [XLEN-1:0]   rem_q, rem_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic              q_neg_q, q_neg_nx;
    logic              r_neg_q, r_neg_nx;
    logic [XLEN-1:0]   result_nx;

    logic              is_w, is_sgn, is_rem;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_neg;
    logic              s1, s2, div0, ovf;
    logic [XLEN-1:0]   spec_sel, spec_res;
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   q_fix, r_fix, fix_sel, fix_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Operand preparation: width adjust, signs, magnitudes and special cases
    always_comb begin
        is_w    = op_q[2];
        is_sgn  = ~op_q[0];
        is_rem  = op_q[1];
        if (is_w) begin
            a_ext = is_sgn ? sext32(a_q[31:0]) : {{(XLEN-32){1'b0}}, a_q[31:0]};
            b_ext = is_sgn ? sext32(b_q[31:0]) : {{(XLEN-32){1'b0}}, b_q[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_ext = a_q;
            b_ext = b_q;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        s1    = is_sgn & a_ext[XLEN-1];
        s2    = is_sgn & b_ext[XLEN-1];
        a_abs = s1 ? -a_ext : a_ext;
        b_abs = s2 ? -b_ext : b_ext;
        div0  = (b_ext == '0);
        ovf   = is_sgn && (a_ext == min_neg) && (&b_ext);
        if (div0) spec_sel = is_rem ? a_ext : '1;
        else      spec_sel = is_rem ? '0 : a_ext;
        spec_res = is_w ? sext32(spec_sel[31:0]) : spec_sel;
    end

    // Restoring step and final sign correction
    always_comb begin
        rem_sh  = {rem_q, a_q[XLEN-1]};
        ge      = (rem_sh >= {1'b0, b_q});
        q_fix   = q_neg_q ? -a_q : a_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;
        fix_sel = is_rem ? r_fix : q_fix;
        fix_res = is_w ? sext32(fix_sel[31:0]) : fix_sel;
    end

    always_comb begin
        state_nx  = state_q;
        op_nx     = op_q;
        a_nx      = a_q;
        b_nx      = b_q;
        rem_nx    = rem_q;
        cnt_nx    = cnt_q;
        q_neg_nx  = q_neg_q;
        r_neg_nx  = r_neg_q;
        result_nx = resp_result;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_nx    = req_op;
                    a_nx     = req_rs1;
                    b_nx     = req_rs2;
                    state_nx = PREP;
                end
            end
            PREP: begin
                q_neg_nx = s1 ^ s2;
                r_neg_nx = s1;
                if (div0 || ovf) begin
                    result_nx = spec_res;
                    state_nx  = DONE;
                end else begin
                    // W-ops: park the 32-bit dividend in the top half so its MSB shifts out first
                    a_nx     = is_w ? (a_abs << HW) : a_abs;
                    b_nx     = b_abs;
                    rem_nx   = '0;
                    cnt_nx   = is_w ? CW'(HW - 1) : CW'(XLEN - 1);
                    state_nx = CALC;
                end
            end
            CALC: begin
                a_nx   = {a_q[XLEN-2:0], ge};
                rem_nx = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
                if (cnt_q == '0) state_nx = FIX;
                else             cnt_nx   = cnt_q - CW'(1);
            end
            FIX: begin
                result_nx = fix_res;
                state_nx  = DONE;
            end
            DONE: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
        if (state_nx == IDLE) result_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
        end else begin
            state_q     <= state_nx;
            op_q        <= op_nx;
            a_q         <= a_nx;
            b_q         <= b_nx;
            rem_q       <= rem_nx;
            cnt_q       <= cnt_nx;
            q_neg_q     <= q_neg_nx;
            r_neg_q     <= r_neg_nx;
            req_ready   <= (state_nx == IDLE);
            resp_valid  <= (state_nx == DONE);
            resp_result <= result_nx;
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: results, latency, back-pressure, flush and reset.
module tb_mdu_divider;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    int n_checks = 0;
    int n_errors = 0;

    mdu_divider #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    // Issue one op, measure latency (posedges after accept until resp_valid seen), check result,
    // optionally hold resp_ready low for 'hold' cycles, then complete the handshake.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input int hold);
        int idx;
        @(negedge clk);
        check({tag, ":rdy"}, 64'(req_ready), 64'd1);
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_op     = op;
        req_rs1    = a;
        req_rs2    = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
        idx = 0;
        do begin
            @(negedge clk);
            idx++;
        end while (!resp_valid && idx < 200);
        if (!resp_valid) begin
            check({tag, ":timeout"}, 64'(resp_valid), 64'd1);
            resp_ready = 1'b1;
            return;
        end
        check({tag, ":lat"}, 64'(idx), 64'(lat));
        check({tag, ":res"}, resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ":hold_v"}, 64'(resp_valid), 64'd1);
            check({tag, ":hold_r"}, resp_result, exp);
            check({tag, ":hold_rdy"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, ":drop_v"}, 64'(resp_valid), 64'd0);
        check({tag, ":idle_rdy"}, 64'(req_ready), 64'd1);
        check({tag, ":idle_res"}, resp_result, 64'd0);
    endtask

    // Start a long op, then kill it with flush or rst mid-CALC; no response may follow.
    task automatic kill_op(input string tag, input bit use_rst);
        int seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_rs1   = 64'd1000;
        req_rs2   = 64'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        check({tag, ":rdy"}, 64'(req_ready), 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check({tag, ":no_resp"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:req_ready", 64'(req_ready), 64'd1);
        check("rst:resp_valid", 64'(resp_valid), 64'd0);
        check("rst:resp_result", resp_result, 64'd0);
        rst = 1'b0;

        do_op("divu",  3'd1, 64'd100, 64'd7, 64'd14, 67, 0);
        do_op("remu",  3'd3, 64'd100, 64'd7, 64'd2, 67, 0);
        do_op("div_n", 3'd0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
        do_op("rem_n", 3'd2, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
        do_op("rem_p", 3'd2, 64'd7, -64'sd2, 64'd1, 67, 0);
        do_op("div0",  3'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        do_op("remu0", 3'd3, 64'h1234, 64'd0, 64'h1234, 2, 0);
        do_op("ovf_d", 3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 2, 0);
        do_op("ovf_r", 3'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 0);
        do_op("divw_ovf", 3'd4, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 2, 0);
        do_op("divuw", 3'd5, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
        do_op("remw",  3'd6, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
        do_op("divw",  3'd4, 64'hABCD_0000_0000_0064, 64'd7, 64'd14, 35, 0);
        do_op("remuw0", 3'd7, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        do_op("hold",  3'd1, 64'd1000, 64'd10, 64'd100, 67, 10);

        kill_op("flush", 1'b0);
        do_op("post_flush", 3'd1, 64'd9, 64'd3, 64'd3, 67, 0);
        kill_op("rst", 1'b1);
        do_op("post_rst", 3'd1, 64'd9, 64'd3, 64'd3, 67, 0);

        // flush in IDLE discards a simultaneous request
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 3'd1;
        req_rs1   = 64'd50;
        req_rs2   = 64'd0;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle_flush:rdy", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("idle_flush:no_resp", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
